// File: rtl/jit_cf_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : jit_cf_scheduler
// Purpose  : Round-robin scheduler that shares one 8-bit JIT control-flow
//            datapath (out = a + b + (a == b ? 5 : 6), mod 256) among N
//            requesters. The winning operands are computed and registered with
//            the requester id in a one-entry output stage, and output
//            handshakes are counted.
// Ports    : clk, rst_n (async assert, active-low)
//            in_valid/in_ready [N]     per-requester request handshake
//            in_a/in_b [N*8]           operands, requester i at [8i+7:8i]
//            out_valid/out_ready       result handshake
//            out_data [8], out_id [IDW] result and originating requester
//            done_cnt [CNTW]           wrapping count of output handshakes
// Revision : 1.0 - initial release
// ============================================================================
module jit_cf_scheduler #(
    parameter int N    = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*8-1:0]  in_a,
    input  logic [N*8-1:0]  in_b,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic [IDW-1:0]  out_id,
    input  logic            out_ready,
    output logic [CNTW-1:0] done_cnt
);

    logic [IDW-1:0]  r_ptr;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic [IDW-1:0]  r_out_id;
    logic [CNTW-1:0] r_done_cnt;

    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;
    logic            w_can_accept;
    logic            w_in_fire;
    logic            w_out_fire;
    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic [7:0]      w_sum;
    logic            w_eq;
    logic [7:0]      w_result;
    logic [IDW-1:0]  w_ptr_next;

    // Scan ptr, ptr+1, ..., wrapping; the first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % N);
            if (!w_found && in_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // A new result may load in the same cycle the old one drains.
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_in_fire    = w_found && w_can_accept;
    assign w_out_fire   = r_out_valid && out_ready;

    always_comb begin
        in_ready = '0;
        if (w_in_fire) begin
            in_ready[w_win] = 1'b1;
        end
    end

    // Datapath: equality is judged on the raw operands, not on the sum.
    assign w_a      = in_a[{w_win, 3'b000} +: 8];
    assign w_b      = in_b[{w_win, 3'b000} +: 8];
    assign w_sum    = w_a + w_b;
    assign w_eq     = (w_a == w_b);
    assign w_result = w_sum + (w_eq ? 8'd5 : 8'd6);

    assign w_ptr_next = (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_done_cnt  <= '0;
        end else begin
            if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
                r_out_id    <= w_win;
                r_ptr       <= w_ptr_next;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_fire) begin
                r_done_cnt <= r_done_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign done_cnt  = r_done_cnt;

endmodule
`default_nettype wire
